// File: rtl/lsu_pkg.sv
// Shared encodings and alignment helpers for the load/store unit.
// Optional feature macro used by this slice: LSU_MISALIGN_TRAP_EN.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_t;

  // Size 2'b11 falls into the word case everywhere.
  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      default: return (off != 2'b00);
    endcase
  endfunction

  function automatic logic [1:0] lsu_align_off(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return off;
      SZ_HALF: return {off[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts/extends load data from a memory word and
// merges sub-word store data into the addressed byte lane(s).
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_offset,
  input  logic        i_unsigned,
  input  logic [15:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merged
);

  logic signed [7:0]  w_byte;
  logic signed [15:0] w_half;

  always_comb begin
    w_byte = i_word[{i_offset, 3'b000} +: 8];
    w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];

    case (i_size)
      SZ_BYTE: o_load_data = i_unsigned ? {24'd0, w_byte} : 32'(w_byte);
      SZ_HALF: o_load_data = i_unsigned ? {16'd0, w_half} : 32'(w_half);
      default: o_load_data = i_word;
    endcase

    o_merged = i_word;
    case (i_size)
      SZ_BYTE: o_merged[{i_offset, 3'b000} +: 8] = i_wdata[7:0];
      SZ_HALF: begin
        if (i_offset[1]) o_merged[31:16] = i_wdata;
        else             o_merged[15:0]  = i_wdata;
      end
      default: o_merged = i_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: IDLE/READ/WRITE/RESP FSM between a core and a word memory.
// Define LSU_MISALIGN_TRAP_EN to report misaligned accesses via resp_err.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_ADDR_BITS = 14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_we
);

  localparam logic [31:0] ADDR_MASK = (MEM_ADDR_BITS >= 32) ? 32'hFFFF_FFFF :
                                      ((32'd1 << MEM_ADDR_BITS) - 32'd1);

  lsu_state_t  r_state;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic        r_mem_we;
  logic [31:0] r_resp_rdata;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_mem_address;

  logic        r_we;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_offset;
  logic [15:0] r_wdata;

  logic        w_handshake;
  logic        w_misaligned;
  logic        w_subword;
  logic [1:0]  w_offset;
  logic [31:0] w_word_addr;
  logic [31:0] w_load_data;
  logic [31:0] w_merged;

  assign req_ready   = (r_state == ST_IDLE) && !reset;
  assign w_handshake = req_valid && req_ready;
  assign w_subword   = (req_size == SZ_BYTE) || (req_size == SZ_HALF);
  assign w_word_addr = req_addr & ADDR_MASK & 32'hFFFF_FFFC;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misaligned = lsu_misaligned(req_size, req_addr[1:0]);
  assign w_offset     = req_addr[1:0];
`else
  // Without the trap, misaligned low bits are dropped to the access size.
  assign w_misaligned = 1'b0;
  assign w_offset     = lsu_align_off(req_size, req_addr[1:0]);
`endif

  assign resp_valid  = r_resp_valid;
  assign resp_err    = r_resp_err;
  assign resp_rdata  = r_resp_rdata;
  assign mem_we      = r_mem_we;
  assign mem_wdata   = r_mem_wdata;
  assign mem_address = r_mem_address;

  lsu_align u_align (
    .i_word      (mem_rdata),
    .i_size      (r_size),
    .i_offset    (r_offset),
    .i_unsigned  (r_unsigned),
    .i_wdata     (r_wdata),
    .o_load_data (w_load_data),
    .o_merged    (w_merged)
  );

  // Request fields are pure data and carry no reset.
  always_ff @(posedge clk) begin
    if (w_handshake) begin
      r_we       <= req_we;
      r_size     <= req_size;
      r_unsigned <= req_unsigned;
      r_offset   <= w_offset;
      r_wdata    <= req_wdata[15:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_resp_valid  <= 1'b0;
      r_resp_err    <= 1'b0;
      r_mem_we      <= 1'b0;
      r_resp_rdata  <= 32'd0;
      r_mem_wdata   <= 32'd0;
      r_mem_address <= 32'd0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_mem_we     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_handshake) begin
            r_mem_address <= w_word_addr;
            if (w_misaligned) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= 32'd0;
            end else if (!req_we || w_subword) begin
              r_state <= ST_READ;
            end else begin
              r_state     <= ST_WRITE;
              r_mem_we    <= 1'b1;
              r_mem_wdata <= req_wdata;
            end
          end
        end
        ST_READ: begin
          if (r_we) begin
            r_state     <= ST_WRITE;
            r_mem_we    <= 1'b1;
            r_mem_wdata <= w_merged;
          end else begin
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= w_load_data;
          end
        end
        ST_WRITE: begin
          r_state      <= ST_RESP;
          r_resp_valid <= 1'b1;
          r_resp_rdata <= 32'd0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word memory model at byte 0x100.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_address, mem_wdata, mem_rdata;

  logic [31:0] mem [0:4095];

  int n_pass = 0;
  int n_total = 0;

  int          resp_lat, we_lat, resp_cnt, we_cnt;
  logic [31:0] got_rdata, got_addr;
  logic        got_err;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_address[13:2]];
  always @(posedge clk) if (mem_we) mem[mem_address[13:2]] <= mem_wdata;

  load_store_unit #(.MEM_ADDR_BITS(14)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_we(mem_we)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Issue one request at a negedge, then watch 6 cycles; cycle k is the window
  // ending at posedge T+k where T is the handshake edge.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    check("req_ready_before", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    resp_lat = 0; we_lat = 0; resp_cnt = 0; we_cnt = 0;
    got_rdata = 32'hX; got_err = 1'bx; got_addr = 32'hX;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = 1'b0;
        got_addr = mem_address;
      end
      if (resp_valid) begin
        resp_cnt++;
        if (resp_lat == 0) begin
          resp_lat = k; got_rdata = resp_rdata; got_err = resp_err;
        end
      end
      if (mem_we) begin
        we_cnt++;
        if (we_lat == 0) we_lat = k;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
    mem[32'h100 >> 2] = 32'h8899AABB;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;

    repeat (2) @(negedge clk);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    reset = 1'b0;

    // LB 0x103 signed
    do_req(1'b0, 2'b00, 1'b0, 32'h103, 32'd0);
    check("lb_rdata", got_rdata, 32'hFFFFFF88);
    check("lb_lat", resp_lat, 2);
    check("lb_resp_cnt", resp_cnt, 1);
    check("lb_we_cnt", we_cnt, 0);
    check("lb_mem_addr", got_addr, 32'h100);
    check("lb_err", {31'd0, got_err}, 32'd0);

    do_req(1'b0, 2'b01, 1'b1, 32'h102, 32'd0);
    check("lhu_rdata", got_rdata, 32'h00008899);
    check("lhu_lat", resp_lat, 2);

    do_req(1'b0, 2'b00, 1'b1, 32'h101, 32'd0);
    check("lbu_rdata", got_rdata, 32'h000000AA);

    do_req(1'b0, 2'b01, 1'b0, 32'h100, 32'd0);
    check("lh_rdata", got_rdata, 32'hFFFFAABB);

    // Upper address bits beyond MEM_ADDR_BITS are dropped
    do_req(1'b0, 2'b10, 1'b0, 32'hFFFF0100, 32'd0);
    check("lw_rdata", got_rdata, 32'h8899AABB);
    check("lw_mem_addr", got_addr, 32'h00000100);

    // SB 0x102
    do_req(1'b1, 2'b00, 1'b0, 32'h102, 32'h12345655);
    check("sb_we_cnt", we_cnt, 1);
    check("sb_we_lat", we_lat, 2);
    check("sb_resp_lat", resp_lat, 3);
    check("sb_rdata", got_rdata, 32'd0);
    check("sb_mem", mem[32'h100 >> 2], 32'h8855AABB);

    // SW 0x100
    do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
    check("sw_we_cnt", we_cnt, 1);
    check("sw_we_lat", we_lat, 1);
    check("sw_resp_lat", resp_lat, 2);
    check("sw_mem", mem[32'h100 >> 2], 32'hDEADBEEF);

    // SH 0x101 (misaligned)
    do_req(1'b1, 2'b01, 1'b0, 32'h101, 32'h0000CAFE);
`ifdef LSU_MISALIGN_TRAP_EN
    check("sh_mis_err", {31'd0, got_err}, 32'd1);
    check("sh_mis_lat", resp_lat, 1);
    check("sh_mis_we_cnt", we_cnt, 0);
    check("sh_mis_mem", mem[32'h100 >> 2], 32'hDEADBEEF);
    do_req(1'b0, 2'b11, 1'b0, 32'h100, 32'd0);
    check("lw_sz3_rdata", got_rdata, 32'hDEADBEEF);
`else
    check("sh_trunc_err", {31'd0, got_err}, 32'd0);
    check("sh_trunc_we_lat", we_lat, 2);
    check("sh_trunc_resp_lat", resp_lat, 3);
    check("sh_trunc_mem", mem[32'h100 >> 2], 32'hDEADCAFE);
    do_req(1'b0, 2'b11, 1'b0, 32'h100, 32'd0);
    check("lw_sz3_rdata", got_rdata, 32'hDEADCAFE);
`endif
    check("lw_sz3_lat", resp_lat, 2);

    // Reset during READ of SB 0x100
    got_rdata = mem[32'h100 >> 2];
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h100; req_wdata = 32'h00000077;
    @(posedge clk);
    we_cnt = 0; resp_cnt = 0;
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_mid_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (mem_we) we_cnt++;
      if (resp_valid) resp_cnt++;
      @(negedge clk);
    end
    check("rst_mid_we_cnt", we_cnt, 0);
    check("rst_mid_resp_cnt", resp_cnt, 0);
    check("rst_mid_ready_after", {31'd0, req_ready}, 32'd1);
    check("rst_mid_mem", mem[32'h100 >> 2], got_rdata);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
